// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low matrix keypad, debounces whole-scan
// results, and turns decimal key presses into an 8-bit value (0..255).
// Keys: 0-9 digits, C clear, E enter, A/B/D/F ignored.
// Optional build macro KEYPAD_BACKSPACE_EN turns key D into backspace.
module keypad_entry #(
  parameter int COUNTER_BITS   = 12,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_key,
  output logic       o_key_valid,
  output logic [7:0] o_acc,
  output logic [1:0] o_digits,
  output logic [7:0] o_value,
  output logic       o_valid,
  output logic       o_err
);

  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

  logic [COUNTER_BITS-1:0] scan_cnt;
  logic [1:0]              col_idx;
  logic [3:0]              row_meta;
  logic [3:0]              row_sync;
  logic [1:0]              low_total;    // low bits seen this scan: 0, 1, 2 = many
  logic [3:0]              low_code;     // code of the first low bit seen this scan
  logic [4:0]              prev_result;  // {key present, code}
  logic [4:0]              deb_state;
  logic [3:0]              stab_cnt;

  logic       sample;
  logic       end_scan;
  logic [3:0] row_low;
  logic [2:0] this_cnt;
  logic [1:0] this_row;
  logic [2:0] sum_cnt;
  logic [1:0] scan_total;
  logic [3:0] scan_code;
  logic [4:0] result;
  logic [3:0] next_stab;
  logic       accept;
  logic       press;
  logic [11:0] prod;
  logic       digit_ok;

  // Scan sampling and end-of-scan result / debounce decision.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    sample     = &scan_cnt;
    end_scan   = sample && (col_idx == 2'd3);
    row_low    = ~row_sync;
    this_cnt   = {2'b00, row_low[0]} + {2'b00, row_low[1]}
               + {2'b00, row_low[2]} + {2'b00, row_low[3]};
    this_row   = 2'd0;
    if      (row_low[0]) this_row = 2'd0;
    else if (row_low[1]) this_row = 2'd1;
    else if (row_low[2]) this_row = 2'd2;
    else if (row_low[3]) this_row = 2'd3;
    sum_cnt    = {1'b0, low_total} + this_cnt;
    scan_total = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    scan_code  = (low_total == 2'd0) ? {this_row, col_idx} : low_code;
    result     = (scan_total == 2'd1) ? {1'b1, scan_code} : 5'd0;
    if (result == prev_result)
      next_stab = (stab_cnt >= DEB_MAX) ? DEB_MAX : stab_cnt + 4'd1;
    else
      next_stab = 4'd1;
    accept     = (next_stab == DEB_MAX);
    press      = end_scan && accept && result[4] && !deb_state[4];
    prod       = 12'(o_acc) * 12'd10 + 12'(result[3:0]);
    digit_ok   = (o_digits < 2'd3) && (prod <= 12'd255);
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!i_rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= i_row;
      row_sync <= row_meta;
    end
  end

  // Column dwell counter, column drive and per-scan accumulation of low rows.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scan_cnt  <= '0;
      col_idx   <= 2'd0;
      o_col     <= 4'b1110;
      low_total <= 2'd0;
      low_code  <= 4'd0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (sample) begin
        col_idx <= col_idx + 2'd1;
        o_col   <= ~(4'b0001 << (col_idx + 2'd1));
        if (end_scan) begin
          low_total <= 2'd0;
          low_code  <= 4'd0;
        end else begin
          low_total <= scan_total;
          low_code  <= scan_code;
        end
      end
    end
  end

  // Debounce: a scan result must repeat DEBOUNCE_SCANS times to be accepted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_result <= 5'd0;
      deb_state   <= 5'd0;
      stab_cnt    <= 4'd0;
    end else if (end_scan) begin
      prev_result <= result;
      stab_cnt    <= next_stab;
      if (accept) deb_state <= result;
    end
  end

  // Key event handling: digit accumulation, clear, enter, optional backspace.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_key       <= 4'd0;
      o_key_valid <= 1'b0;
      o_acc       <= 8'd0;
      o_digits    <= 2'd0;
      o_value     <= 8'd0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
      if (press) begin
        o_key       <= result[3:0];
        o_key_valid <= 1'b1;
        case (result[3:0])
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
            if (digit_ok) begin
              o_acc    <= prod[7:0];
              o_digits <= o_digits + 2'd1;
            end else begin
              o_err <= 1'b1;
            end
          end
          4'hC: begin
            o_acc    <= 8'd0;
            o_digits <= 2'd0;
          end
          4'hE: begin
            if (o_digits != 2'd0) begin
              o_value  <= o_acc;
              o_valid  <= 1'b1;
              o_acc    <= 8'd0;
              o_digits <= 2'd0;
            end
          end
`ifdef KEYPAD_BACKSPACE_EN
          4'hD: begin
            if (o_digits != 2'd0) begin
              o_acc    <= o_acc / 8'd10;
              o_digits <= o_digits - 2'd1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Input-side companion to the three-digit seven-segment display. Scans a 4x4 matrix keypad, debounces it and decodes key presses. Decimal digits accumulate into an 8-bit value, so up to three digits are entered to form 0..255, which is the inverse of the display's binary-to-decimal decode. On Enter the block presents the value with a one-cycle strobe, which the display's write enable or a bus register can consume.

Parameters:
COUNTER_BITS, 12, log2 of clock cycles each column is driven (column dwell = 2^COUNTER_BITS cycles)
DEBOUNCE_SCANS, 4, consecutive identical full scans required before a key state is accepted (1..15)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_row  input  4  keypad rows, active-low, externally pulled up
o_col  output  4  keypad column drive, one-hot active-low
o_key  output  4  code of last accepted key press
o_key_valid  output  1  one-cycle pulse per accepted key press
o_acc  output  8  value being entered, feeds the display during entry
o_digits  output  2  number of digits in o_acc (0..3)
o_value  output  8  last committed value
o_valid  output  1  one-cycle pulse when o_value is committed
o_err  output  1  one-cycle pulse when a digit is rejected

Behaviour:
- Reset (i_rst_n=0 sampled at rising edge): scan counter=0, column index=0, o_col=4'b1110, debounced state=none, stability count=0. All other outputs are 0.
- Scan: the counter increments every cycle.
  - Rows are sampled on the cycle counter==all-ones, after settling.
  - Column index then advances 0->1->2->3->0 on the wrap.
  - o_col = ~(1<<index), registered.
- Key code = 4*row_bit_index + column_index. Board wiring makes the code equal the printed hex legend.
- Scan result after column 3 is sampled:
  - exactly one low row bit over the whole scan -> that key;
  - zero low bits -> none;
  - two or more low bits -> none (ghosting/multi-key rejected).
- Debounce:
  - If the scan result equals the previous scan result, the stability count increments, saturating at DEBOUNCE_SCANS. Otherwise the count resets to 1.
  - When the count reaches DEBOUNCE_SCANS, the result becomes the debounced state.
  - A press event occurs only on a debounced transition from none to key. Holding a key gives exactly one event. A direct key->key debounced change gives no event; the release must be seen first.
- Press event, registered on the end-of-scan cycle, acted on the next cycle (t+1). At t+1 o_key=code and o_key_valid=1. In that same cycle:
  - 0..9: if o_digits<3 and o_acc*10+d <= 255 (computed 12-bit wide), then o_acc <= o_acc*10+d and o_digits += 1. Otherwise o_acc is unchanged and o_err=1.
  - 0xC (clear): o_acc=0, o_digits=0.
  - 0xE (enter): if o_digits>0, then o_value=o_acc, o_valid=1, o_acc=0, o_digits=0. If o_digits==0, no effect.
  - 0xA, 0xB, 0xD, 0xF: no effect on the accumulator (0xD is redefined under the optional feature).
- Pulses o_key_valid, o_valid and o_err are high for exactly one cycle.
- Reset mid-entry or mid-scan discards the partial value and the debounce history. A key held across reset yields a fresh press after DEBOUNCE_SCANS scans.

Optional Feature:
KEYPAD_BACKSPACE_EN
- Defined: key 0xD is backspace. If o_digits>0, then o_acc <= o_acc/10 and o_digits -= 1. If o_digits==0, no effect.
- Undefined: 0xD is ignored like the other non-digit keys. No divider is instantiated.

Test Plan:
All tests use COUNTER_BITS=2 and DEBOUNCE_SCANS=2, so the scan period is 16 cycles.
- Reset, rows all high -> o_col 1110, 1101, 1011, 0111 each held 4 cycles, then repeats. No pulses, all outputs 0.
- Press keys 1, 2, 5, then E, each held 3 scans with releases between -> four o_key_valid pulses. o_acc steps 1, 12, 125. Then o_value=125 with a single o_valid pulse, and o_acc=0, o_digits=0.
- Enter 2, 5, 6 -> third digit sets o_err for one cycle and o_acc stays 25. Enter 1, 2, 3, 4 -> fourth digit gives o_err and o_acc=123. Enter -> o_value=123.
- Key 7 low for only one scan, or keys 3 and 6 low together for 5 scans -> no o_key_valid, o_acc unchanged.
- Hold key 9 for 10 scans -> exactly one o_key_valid. Assert reset during a held 4 with o_acc=12 -> o_acc=0. After release of reset, one new press of 4 arrives 2 scans later, giving o_acc=4.
- With KEYPAD_BACKSPACE_EN: 1, 2, D -> o_acc=1, o_digits=1. D, D -> o_acc=0, o_digits=0, no o_err. Without the macro: 1, 2, D -> o_acc=12.
